// File: rtl/antirrebote.sv
// Debouncer for one raw asynchronous bit: 2-flop synchronizer, 4-state stability FSM, registered level and edge pulses.
// Edge pulses (o_subida/o_bajada) are built only when ANTIRREBOTE_FLANCOS_EN is defined; otherwise they are tied to 0.
module antirrebote #(
  parameter int ESTABLE = 8,
  parameter int ANCHO   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_valor,
  output logic o_valor,
  output logic o_subida,
  output logic o_bajada
);

  typedef enum logic [1:0] {BAJO, SUBIENDO, ALTO, BAJANDO} estado_t;

  localparam logic [ANCHO-1:0] CNT_FIN = ANCHO'(ESTABLE - 1);
  localparam logic [ANCHO-1:0] CNT_UNO = ANCHO'(1);

  estado_t          estado_q, estado_d;
  logic [ANCHO-1:0] cnt_q, cnt_d;
  logic             s1_q, s2_q;
  logic             valor_q, valor_d;
  logic             fin;

  assign fin = (cnt_q == CNT_FIN);

  // State register, synchronizer and registered level
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      estado_q <= BAJO;
      cnt_q    <= '0;
      valor_q  <= 1'b0;
    end else begin
      s1_q     <= i_valor;
      s2_q     <= s1_q;
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      valor_q  <= valor_d;
    end
  end

  // Next state: the counter is cleared on every accept or reject, so it never reaches ESTABLE
  always_comb begin
    estado_d = estado_q;
    cnt_d    = '0;
    case (estado_q)
      BAJO: if (s2_q) begin
        estado_d = SUBIENDO;
        cnt_d    = CNT_UNO;
      end
      SUBIENDO: begin
        if (!s2_q)    estado_d = BAJO;
        else if (fin) estado_d = ALTO;
        else          cnt_d    = cnt_q + CNT_UNO;
      end
      ALTO: if (!s2_q) begin
        estado_d = BAJANDO;
        cnt_d    = CNT_UNO;
      end
      BAJANDO: begin
        if (s2_q)     estado_d = ALTO;
        else if (fin) estado_d = BAJO;
        else          cnt_d    = cnt_q + CNT_UNO;
      end
      default: estado_d = BAJO;
    endcase
  end

  // Output next values, registered alongside the state
  always_comb begin
    valor_d = 1'b0;
    case (estado_q)
      BAJO:     valor_d = 1'b0;
      SUBIENDO: valor_d = s2_q && fin;
      ALTO:     valor_d = 1'b1;
      BAJANDO:  valor_d = s2_q || !fin;
      default:  valor_d = 1'b0;
    endcase
  end

  assign o_valor = valor_q;

`ifdef ANTIRREBOTE_FLANCOS_EN
  logic subida_q, bajada_q;
  logic subida_d, bajada_d;

  always_comb begin
    subida_d = (estado_q == SUBIENDO) && s2_q  && fin;
    bajada_d = (estado_q == BAJANDO)  && !s2_q && fin;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      subida_q <= 1'b0;
      bajada_q <= 1'b0;
    end else begin
      subida_q <= subida_d;
      bajada_q <= bajada_d;
    end
  end

  assign o_subida = subida_q;
  assign o_bajada = bajada_q;
`else
  assign o_subida = 1'b0;
  assign o_bajada = 1'b0;
`endif

endmodule

// File: doc/antirrebote.md
# antirrebote

Input conditioning stage for a single raw, asynchronous 1-bit signal such as a push-button or switch. It synchronizes the input to `clk` and rejects glitches shorter than a programmable number of cycles. It also emits one-cycle pulses on each accepted transition. `o_valor` drives the `i_valor` input of the downstream `flipflop` stage directly, so that stage only ever sees a clean, clock-aligned level.

## Interface
- `ESTABLE`, default 8: consecutive cycles the synchronized input must hold a new level before it is accepted. Legal values are 2 to 2^`ANCHO`-1.
- `ANCHO`, default 4: width of the stability counter.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `i_valor` in 1: raw input, asynchronous to `clk`.
- `o_valor` out 1: debounced level. Registered. Reset value 0.
- `o_subida` out 1: one-cycle pulse on an accepted 0→1 transition. Registered. Reset value 0.
- `o_bajada` out 1: one-cycle pulse on an accepted 1→0 transition. Registered. Reset value 0.

## Operation
- Synchronizer: two flops, `s1 <= i_valor` and `s2 <= s1`, both reset to 0. Only `s2` feeds the FSM.
- The FSM has four states: BAJO (reset state), SUBIENDO, ALTO and BAJANDO. Counter `cnt` is `ANCHO` bits and resets to 0.
- BAJO:
  - `s2`=1 → SUBIENDO, `cnt` <= 1.
  - Otherwise hold, `cnt` = 0.
- SUBIENDO:
  - `s2`=0 → BAJO, `cnt` <= 0 (glitch rejected; no output change).
  - `s2`=1 and `cnt`==`ESTABLE`-1 → ALTO, `o_valor` <= 1, `o_subida` <= 1, `cnt` <= 0.
  - Otherwise `cnt` <= `cnt`+1.
- ALTO and BAJANDO mirror BAJO and SUBIENDO with polarity inverted. The accepting transition sets `o_valor` <= 0 and `o_bajada` <= 1.
- `o_subida` and `o_bajada` are high for exactly one cycle. They are never high together. They are asserted in the same cycle in which `o_valor` first shows the new level.
- `o_valor` is 0 in BAJO and SUBIENDO, and 1 in ALTO and BAJANDO.
- The counter never wraps: it is cleared on acceptance or rejection before it can reach `ESTABLE`.
- Unreachable state encodings recover to BAJO with all outputs 0.

## Timing
- Define edge k as the first rising edge that samples `i_valor`=1 into `s1`, with the input held from then on.
  - `s2`=1 after edge k+1.
  - SUBIENDO is entered at edge k+2.
  - `o_valor`=1 and `o_subida`=1 after edge k+`ESTABLE`+1.
- Total latency from first capture to output change is `ESTABLE`+1 edges; for the default that is 9. Falling transitions have the same latency.
- Pulse rejection: an `s2` excursion of fewer than `ESTABLE` consecutive cycles never changes `o_valor`.
- An excursion of exactly `ESTABLE` cycles is accepted.
- Reset has priority over every other condition.
  - `rst`=1 at an edge clears `s1`, `s2`, the state (to BAJO), `cnt` and all outputs at that edge.
  - This includes reset asserted mid-count and reset asserted while a pulse output is high.
  - After reset is released, the Timing rule above applies from the first sampling edge.
- There is no combinational path from any input to any output.

## Configuration
- Macro: `ANTIRREBOTE_FLANCOS_EN`.
- Defined: `o_subida` and `o_bajada` behave as specified above.
- Undefined:
  - `o_subida` and `o_bajada` are constant 0 and their registers are not built.
  - The ports remain in the interface.
  - `o_valor` behaviour and latency are unchanged.

## Test plan
- Reset and idle: assert `rst` for 3 cycles with `i_valor`=1 → `o_valor`, `o_subida` and `o_bajada` stay 0 throughout. After release, with `ESTABLE`=8, `o_valor` rises 9 edges after the first capture of 1.
- Clean edges: hold `i_valor`=1 for 20 cycles, then 0 for 20 cycles → `o_valor` rises, then falls, 9 edges after each respective capture. `o_subida` and `o_bajada` are each a single one-cycle pulse aligned with the `o_valor` change.
- Glitch rejection: drive 1 for 7 cycles, 0 for 3, then 1 for 8 → the first burst produces no change. `o_valor`=1 only after the 8-cycle burst completes, with exactly one `o_subida` pulse.
- Bounce train: alternate `i_valor` every 2 cycles for 30 cycles, then hold 0 → `o_valor` stays 0 and no pulses occur.
- Reset mid-count: drive 1 and assert `rst` at edge k+5 for 1 cycle, keeping `i_valor`=1 → no change before reset. `o_valor` rises 9 edges after the first post-reset capture.
- Macro off: rerun the clean-edges scenario without `ANTIRREBOTE_FLANCOS_EN` → `o_valor` timing is identical, and `o_subida` and `o_bajada` are 0 for the whole run.
